// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a fixed access latency and
// valid/ready request and response channels. One transaction at a time.
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_BITS-1:0] idx_c;
  logic                 err_c;
  logic                 commit_c;
  logic                 mem_we_c;

  // Access decode on the latched request; out-of-range never aliases.
  assign idx_c    = lat_addr[ADDR_BITS+1:2];
  assign err_c    = (lat_addr[1:0] != 2'b00) ||
                    ((lat_addr >> (ADDR_BITS + 2)) != 32'd0);
  assign commit_c = (state == WAIT) && (cnt == '0);
  assign mem_we_c = commit_c && lat_we && !err_c;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_err   <= err_c;
            resp_rdata <= (!lat_we && !err_c) ? mem[idx_c] : 32'd0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for the short-latency build.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_req_valid, r1_req_ready, r1_req_we;
  logic [31:0] r1_req_addr, r1_req_wdata;
  logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
  logic [31:0] r1_resp_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_BITS(6), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_we(r1_req_we),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request, wait for acceptance, then scramble the inputs.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555;
  endtask

  task automatic get_resp(input int acc, input int lat, input string tag,
                          input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(cyc - acc), 32'(lat));
    check({tag, "_data"}, resp_rdata, exp_d);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_e));
  endtask

  task automatic consumed(input string tag);
    @(negedge clk);
    check({tag, "_vld0"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdy1"}, 32'(req_ready), 32'd1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input string tag, input logic [31:0] exp_d, input logic exp_e);
    int acc;
    send(we, addr, wd, acc);
    get_resp(acc, 2, tag, exp_d, exp_e);
    consumed(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int accs [4];
    int n;

    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_we = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    r1_resp_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst1_req_ready", 32'(r1_req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Write then read back.
    xact(1'b1, 32'h0, 32'h1111_1111, "wr0", 32'd0, 1'b0);
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, "wr10", 32'd0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, "rd10", 32'hDEAD_BEEF, 1'b0);

    // Backpressure on the response channel.
    resp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, acc);
    get_resp(acc, 2, "bp", 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_vld", 32'(resp_valid), 32'd1);
      check("bp_hold_data", resp_rdata, 32'hDEAD_BEEF);
      check("bp_hold_rdy", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    consumed("bp");

    // Error cases must not touch memory (0x12 hits word 4, 0x100 would alias word 0).
    xact(1'b1, 32'h12, 32'hBAD0_0001, "mis", 32'd0, 1'b1);
    xact(1'b1, 32'h100, 32'hBAD0_0002, "oor", 32'd0, 1'b1);
    xact(1'b0, 32'h100, 32'h0, "oor_rd", 32'd0, 1'b1);
    xact(1'b0, 32'h0, 32'h0, "rd0_after_err", 32'h1111_1111, 1'b0);
    xact(1'b0, 32'h10, 32'h0, "rd10_after_err", 32'hDEAD_BEEF, 1'b0);

    // Back-to-back reads with req_valid held high.
    xact(1'b1, 32'h0, 32'd1, "pre0", 32'd0, 1'b0);
    xact(1'b1, 32'h4, 32'd2, "pre4", 32'd0, 1'b0);
    xact(1'b1, 32'h8, 32'd3, "pre8", 32'd0, 1'b0);
    xact(1'b1, 32'hC, 32'd4, "preC", 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accept_timeout", 32'(n < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
      accs[i] = cyc;
      if (i < 3) req_addr = 32'(4 * (i + 1));
      else req_valid = 1'b0;
      get_resp(accs[i], 2, "b2b", 32'(i + 1), 1'b0);
      if (i > 0) check("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd4);
    end
    consumed("b2b_end");

    // Reset during WAIT drops an uncommitted write.
    xact(1'b1, 32'h20, 32'hAAAA_AAAA, "pre20", 32'd0, 1'b0);
    send(1'b1, 32'h20, 32'h1234_5678, acc);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    xact(1'b0, 32'h20, 32'h0, "rd20_after_rst", 32'hAAAA_AAAA, 1'b0);

    // LATENCY=1 instance: write then read, response one edge after acceptance.
    @(negedge clk);
    check("l1_rdy_wr", 32'(r1_req_ready), 32'd1);
    r1_req_valid = 1'b1; r1_req_we = 1'b1; r1_req_addr = 32'h8; r1_req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    r1_req_valid = 1'b0; r1_req_addr = 32'h0; r1_req_wdata = 32'h0;
    check("l1_wr_early", 32'(r1_resp_valid), 32'd0);
    @(negedge clk);
    check("l1_wr_vld", 32'(r1_resp_valid), 32'd1);
    check("l1_wr_err", 32'(r1_resp_err), 32'd0);
    @(negedge clk);
    check("l1_rdy_rd", 32'(r1_req_ready), 32'd1);
    r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 32'h8;
    @(posedge clk);
    @(negedge clk);
    r1_req_valid = 1'b0; r1_req_addr = 32'h0;
    check("l1_rd_early", 32'(r1_resp_valid), 32'd0);
    @(negedge clk);
    check("l1_rd_vld", 32'(r1_resp_valid), 32'd1);
    check("l1_rd_data", r1_resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    check("l1_rd_done", 32'(r1_resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the memory end of the processor's load/store interface.
- Accepts one read or write request at a time through a valid/ready handshake.
- Models a fixed access latency, then returns read data and an error flag through a valid/ready response channel.
- Sits between the core's load/store path, or a future multi-cycle wrapper of it, and on-chip RAM.

Parameters:
- ADDR_BITS, 6, log2 of the number of 32-bit words stored (default 64 words).
- LATENCY, 2, number of clock cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  requester presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Memory array is not cleared by reset; contents are undefined until written.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid&&req_ready at edge N: latch we/addr/wdata, load counter with LATENCY-1, go to WAIT.
  - WAIT:
    - req_ready=0.
    - Counter decrements each cycle.
    - At the edge where counter==0, perform the access and go to RESP.
    - resp_valid becomes 1 after edge N+LATENCY.
  - RESP:
    - resp_valid=1.
    - resp_rdata/resp_err are held stable while resp_ready=0.
    - On resp_valid&&resp_ready: clear resp_valid, resp_rdata and resp_err; go to IDLE.
- req_ready depends only on state, never on req_valid; no combinational path from inputs to outputs.
- Access rules, evaluated on the latched request:
  - err = (addr[1:0]!=0) || (addr[31:ADDR_BITS+2]!=0).
  - Read, no err: resp_rdata = mem[addr[ADDR_BITS+1:2]].
  - Write, no err: mem[addr[ADDR_BITS+1:2]] <= wdata; resp_rdata=0.
  - err: no memory update; resp_rdata=0; resp_err=1.
- Input changes after acceptance (addr/wdata/we) have no effect on the transaction in flight.
- Throughput:
  - With resp_ready held 1, a response is consumed at edge N+LATENCY+1, IDLE follows, and the next request is accepted at N+LATENCY+2.
  - Minimum spacing between accepted requests is therefore LATENCY+2 cycles.
  - No pipelining; at most one outstanding transaction.
- req_valid while not ready is ignored; the requester must hold the request until accepted.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with reset values.
  - A write not yet committed (still in WAIT) is dropped; a write already committed remains in memory.
- Write then read of the same address: the read returns the new data (write commits before RESP).
- Address wrap: none. Out-of-range addresses are errors and never alias onto lower words.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, then read 0x10 with LATENCY=2 and resp_ready=1:
  - Write response: resp_valid at acceptance+2, rdata=0, err=0.
  - Read response: resp_rdata=0xDEADBEEF, err=0.
- Backpressure:
  - Read 0x10 with resp_ready=0 for 5 cycles: resp_valid and resp_rdata=0xDEADBEEF stay stable; req_ready=0 throughout.
  - Raise resp_ready: handshake completes, resp_valid=0 next cycle, req_ready=1.
- Errors, each giving resp_err=1, rdata=0, and no memory change:
  - Write to misaligned addr 0x12.
  - Write to out-of-range addr 0x100 (ADDR_BITS=6).
  - Subsequent read of 0x00 returns its prior value.
- Back-to-back:
  - Hold req_valid=1 with 4 reads (0x0,0x4,0x8,0xC) after writing 1,2,3,4.
  - Acceptances occur every LATENCY+2=4 cycles; data returned in order 1,2,3,4.
- Reset mid-operation:
  - Accept a write of 0x12345678 to 0x20, assert reset during WAIT.
  - All outputs return to reset values asynchronously; a later read of 0x20 does not return 0x12345678 (preload 0xAAAAAAAA first, expect 0xAAAAAAAA).
- LATENCY=1 build: a read response appears exactly one edge after acceptance, with correct data.
